// File: rtl/bh_prgmem_loader.sv
// bh_prgmem_loader: encodes a brainfuck source byte stream into instruction words and writes them
// sequentially into program RAM, ending with a halt word. Define BH_LOADER_BRACKET_CHECK_EN for bracket checking.
module bh_prgmem_loader #(
  parameter int PRGMEM_ADDR_WIDTH = 8,
  parameter int INSTR_WIDTH       = 4
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_start,
  input  logic                         i_byte_valid,
  input  logic [7:0]                   i_byte,
  input  logic                         i_byte_last,
  output logic                         o_byte_ready,
  output logic                         o_prgmem_we,
  output logic [PRGMEM_ADDR_WIDTH-1:0] o_prgmem_addr,
  output logic [INSTR_WIDTH-1:0]       o_prgmem_data,
  output logic                         o_cpu_hold,
  output logic                         o_done,
  output logic [1:0]                   o_error,
  output logic [PRGMEM_ADDR_WIDTH-1:0] o_length
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_TERM  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERROR = 3'd4;

  localparam logic [1:0] ERR_OVERFLOW = 2'b01;
  localparam logic [1:0] ERR_BRACKET  = 2'b10;

  logic [2:0]                   state;
  logic [PRGMEM_ADDR_WIDTH-1:0] wptr;
  logic                         term_q;

  function automatic logic [3:0] encode(input logic [7:0] b);
    case (b)
      8'h2B:   encode = 4'd1;  // +
      8'h2D:   encode = 4'd2;  // -
      8'h3E:   encode = 4'd3;  // >
      8'h3C:   encode = 4'd4;  // <
      8'h5B:   encode = 4'd5;  // [
      8'h5D:   encode = 4'd6;  // ]
      8'h2E:   encode = 4'd7;  // .
      8'h2C:   encode = 4'd8;  // ,
      default: encode = 4'd0;
    endcase
  endfunction

  logic [3:0]             code;
  logic [INSTR_WIDTH-1:0] code_ext;
  logic                   is_cmd;
  logic                   hs;
  logic                   at_limit;
  logic                   brk_under;

  assign code     = encode(i_byte);
  assign is_cmd   = (code != 4'd0);
  assign hs       = i_byte_valid & o_byte_ready;
  // The all-ones slot is kept free so the halt word always fits.
  assign at_limit = &wptr;

  always_comb begin
    code_ext      = '0;
    code_ext[3:0] = code;
  end

`ifdef BH_LOADER_BRACKET_CHECK_EN
  logic [PRGMEM_ADDR_WIDTH-1:0] depth;
  assign brk_under = (code == 4'd6) && (depth == '0);
`else
  assign brk_under = 1'b0;
`endif

  assign o_byte_ready = (state == S_LOAD);
  assign o_length     = wptr;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state         <= S_IDLE;
      wptr          <= '0;
      term_q        <= 1'b0;
      o_prgmem_we   <= 1'b0;
      o_prgmem_addr <= '0;
      o_prgmem_data <= '0;
      o_cpu_hold    <= 1'b0;
      o_done        <= 1'b0;
      o_error       <= 2'b00;
`ifdef BH_LOADER_BRACKET_CHECK_EN
      depth         <= '0;
`endif
    end else begin
      o_prgmem_we <= 1'b0;
      term_q      <= (state == S_TERM);

      // Status is published one cycle after the halt write is driven, once the RAM has it.
      if (term_q) begin
        o_cpu_hold <= 1'b0;
        if (state == S_ERROR) o_error <= ERR_BRACKET;
        else                  o_done  <= 1'b1;
      end

      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (i_start) begin
            state      <= S_LOAD;
            wptr       <= '0;
            o_done     <= 1'b0;
            o_error    <= 2'b00;
            o_cpu_hold <= 1'b1;
`ifdef BH_LOADER_BRACKET_CHECK_EN
            depth      <= '0;
`endif
          end
        end
        S_LOAD: begin
          if (hs && is_cmd && at_limit) begin
            state      <= S_ERROR;
            o_error    <= ERR_OVERFLOW;
            o_cpu_hold <= 1'b0;
          end else if (hs && brk_under) begin
            state      <= S_ERROR;
            o_error    <= ERR_BRACKET;
            o_cpu_hold <= 1'b0;
          end else if (hs) begin
            if (is_cmd) begin
              o_prgmem_we   <= 1'b1;
              o_prgmem_addr <= wptr;
              o_prgmem_data <= code_ext;
              wptr          <= wptr + 1'b1;
`ifdef BH_LOADER_BRACKET_CHECK_EN
              if (code == 4'd5)      depth <= depth + 1'b1;
              else if (code == 4'd6) depth <= depth - 1'b1;
`endif
            end
            if (i_byte_last) state <= S_TERM;
          end
        end
        S_TERM: begin
          o_prgmem_we   <= 1'b1;
          o_prgmem_addr <= wptr;
          o_prgmem_data <= '0;
`ifdef BH_LOADER_BRACKET_CHECK_EN
          state         <= (depth != '0) ? S_ERROR : S_DONE;
`else
          state         <= S_DONE;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bh_prgmem_loader.sv
// Directed self-checking bench for bh_prgmem_loader: an 8-bit-address instance for the main flows
// and a 2-bit-address instance for overflow.
module tb_bh_prgmem_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, clr;
  int   n_chk = 0;
  int   n_fail = 0;

  // Main instance (PRGMEM_ADDR_WIDTH = 8)
  logic       start, bv, last;
  logic [7:0] bt;
  logic       ready, we, hold, done;
  logic [7:0] addr, len;
  logic [3:0] data;
  logic [1:0] err;

  bh_prgmem_loader #(.PRGMEM_ADDR_WIDTH(8), .INSTR_WIDTH(4)) dut (
    .i_clock(clk), .i_reset(rst), .i_start(start), .i_byte_valid(bv), .i_byte(bt),
    .i_byte_last(last), .o_byte_ready(ready), .o_prgmem_we(we), .o_prgmem_addr(addr),
    .o_prgmem_data(data), .o_cpu_hold(hold), .o_done(done), .o_error(err), .o_length(len)
  );

  // Small instance (PRGMEM_ADDR_WIDTH = 2)
  logic       b_start, b_bv, b_last;
  logic [7:0] b_bt;
  logic       b_ready, b_we, b_hold, b_done;
  logic [1:0] b_addr, b_len;
  logic [3:0] b_data;
  logic [1:0] b_err;

  bh_prgmem_loader #(.PRGMEM_ADDR_WIDTH(2), .INSTR_WIDTH(4)) dut_small (
    .i_clock(clk), .i_reset(rst), .i_start(b_start), .i_byte_valid(b_bv), .i_byte(b_bt),
    .i_byte_last(b_last), .o_byte_ready(b_ready), .o_prgmem_we(b_we), .o_prgmem_addr(b_addr),
    .o_prgmem_data(b_data), .o_cpu_hold(b_hold), .o_done(b_done), .o_error(b_err), .o_length(b_len)
  );

  // Program RAM models with write counters and write-address logs
  logic [3:0] mem [256];
  logic [3:0] b_mem [4];
  int         wcount, b_wcount;
  int         wlog [16];

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 4'hF;
      for (int i = 0; i < 4; i++) b_mem[i] <= 4'hF;
      wcount   <= 0;
      b_wcount <= 0;
    end else begin
      if (we) begin
        mem[addr] <= data;
        if (wcount < 16) wlog[wcount] <= int'(addr);
        wcount <= wcount + 1;
      end
      if (b_we) begin
        b_mem[b_addr] <= b_data;
        b_wcount <= b_wcount + 1;
      end
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Returns #1 after the edge that takes the final byte.
  task automatic send(input string s, input bit use_last, input bit randv);
    for (int i = 0; i < s.len(); i++) begin
      int  tries;
      bit  taken;
      tries = 0;
      taken = 1'b0;
      bt    = s[i];
      last  = use_last && (i == s.len() - 1);
      while (!taken) begin
        bv = randv ? 1'($urandom_range(0, 1)) : 1'b1;
        if (randv) start = 1'($urandom_range(0, 1));
        taken = bv && ready;
        tick();
        tries++;
        if (!taken && tries > 40) begin
          chk("handshake_timeout", 0, 1);
          taken = 1'b1;
        end
      end
    end
    bv    = 1'b0;
    last  = 1'b0;
    start = 1'b0;
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!(done || err != 2'b00) && n < 20) begin
      tick();
      n++;
    end
    chk("end_reached", int'(done || err != 2'b00), 1);
  endtask

  initial begin
    int exp1 [8];
    exp1 = '{1, 5, 2, 3, 1, 4, 6, 0};
    rst = 1'b1; clr = 1'b1;
    start = 1'b0; bv = 1'b0; last = 1'b0; bt = 8'h00;
    b_start = 1'b0; b_bv = 1'b0; b_last = 1'b0; b_bt = 8'h00;
    repeat (2) tick();
    rst = 1'b0; clr = 1'b0;

    // Reset state
    chk("rst_ready", int'(ready), 0);
    chk("rst_we", int'(we), 0);
    chk("rst_hold", int'(hold), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_len", int'(len), 0);
    chk("rst_addr", int'(addr), 0);
    chk("rst_small_ready", int'(b_ready), 0);

    // "+[->+<]" with halt timing
    do_start();
    chk("t1_ready_after_start", int'(ready), 1);
    chk("t1_hold_after_start", int'(hold), 1);
    send("+[->+<]", 1'b1, 1'b0);
    chk("t1_term_ready", int'(ready), 0);
    chk("t1_term_hold", int'(hold), 1);
    tick();
    chk("t1_halt_we", int'(we), 1);
    chk("t1_halt_addr", int'(addr), 7);
    chk("t1_halt_data", int'(data), 0);
    chk("t1_halt_done_low", int'(done), 0);
    chk("t1_halt_hold_high", int'(hold), 1);
    tick();
    chk("t1_done", int'(done), 1);
    chk("t1_hold_fall", int'(hold), 0);
    chk("t1_we_low", int'(we), 0);
    chk("t1_err", int'(err), 0);
    chk("t1_len", int'(len), 7);
    chk("t1_wcount", wcount, 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t1_mem%0d", i), int'(mem[i]), exp1[i]);
      chk($sformatf("t1_order%0d", i), wlog[i], i);
    end

    // Non-command bytes dropped
    clear_log();
    do_start();
    send("a+ b\n.", 1'b1, 1'b0);
    wait_end();
    chk("t2_mem0", int'(mem[0]), 1);
    chk("t2_mem1", int'(mem[1]), 7);
    chk("t2_mem2", int'(mem[2]), 0);
    chk("t2_len", int'(len), 2);
    chk("t2_wcount", wcount, 3);
    chk("t2_done", int'(done), 1);

    // Overflow on the 2-bit instance
    clear_log();
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    b_bv = 1'b1;
    b_bt = 8'h2B;
    repeat (4) tick();
    b_bv = 1'b0;
    chk("t3_err", int'(b_err), 1);
    chk("t3_hold", int'(b_hold), 0);
    chk("t3_ready", int'(b_ready), 0);
    chk("t3_done", int'(b_done), 0);
    tick();
    chk("t3_wcount", b_wcount, 3);
    chk("t3_mem2", int'(b_mem[2]), 1);
    chk("t3_mem3_untouched", int'(b_mem[3]), 15);
    chk("t3_len", int'(b_len), 3);

    // "+]"
    clear_log();
    do_start();
    send("+]", 1'b1, 1'b0);
    wait_end();
    tick();
    chk("t4_mem0", int'(mem[0]), 1);
`ifdef BH_LOADER_BRACKET_CHECK_EN
    chk("t4_err", int'(err), 2);
    chk("t4_done", int'(done), 0);
    chk("t4_wcount", wcount, 1);
    chk("t4_len", int'(len), 1);
`else
    chk("t4_err", int'(err), 0);
    chk("t4_done", int'(done), 1);
    chk("t4_wcount", wcount, 3);
    chk("t4_len", int'(len), 2);
`endif

    // "[[]"
    clear_log();
    do_start();
    send("[[]", 1'b1, 1'b0);
    wait_end();
    chk("t5_mem2", int'(mem[2]), 6);
    chk("t5_mem3_halt", int'(mem[3]), 0);
    chk("t5_wcount", wcount, 4);
    chk("t5_len", int'(len), 3);
    chk("t5_hold", int'(hold), 0);
`ifdef BH_LOADER_BRACKET_CHECK_EN
    chk("t5_err", int'(err), 2);
    chk("t5_done", int'(done), 0);
`else
    chk("t5_err", int'(err), 0);
    chk("t5_done", int'(done), 1);
`endif

    // Reset in the middle of a load
    do_start();
    send("+++", 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_ready", int'(ready), 0);
    chk("t6_we", int'(we), 0);
    chk("t6_hold", int'(hold), 0);
    chk("t6_done", int'(done), 0);
    chk("t6_err", int'(err), 0);
    chk("t6_len", int'(len), 0);
    tick();
    chk("t6_idle_ready", int'(ready), 0);

    // Reload with random valid gaps and stray start pulses
    clear_log();
    do_start();
    send("-x<", 1'b1, 1'b1);
    wait_end();
    chk("t7_mem0", int'(mem[0]), 2);
    chk("t7_mem1", int'(mem[1]), 4);
    chk("t7_mem2", int'(mem[2]), 0);
    chk("t7_order1", wlog[1], 1);
    chk("t7_wcount", wcount, 3);
    chk("t7_len", int'(len), 2);
    chk("t7_done", int'(done), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bh_prgmem_loader.md
# bh_prgmem_loader

Program-memory writer for the brainhack core: accepts a brainfuck source byte stream over a valid/ready handshake, encodes each command character into an instruction word, and writes the words sequentially into the program RAM that the core fetches from. Non-command bytes are discarded. The program is terminated with a halt word. `o_cpu_hold` keeps the core stalled while a load is in progress.

## Interface
- `PRGMEM_ADDR_WIDTH`, default 8: program memory address width; capacity is 2^W words.
- `INSTR_WIDTH`, default 4: instruction word width; must be ≥ 4.

- `i_clock`, in, 1: the single clock; all state changes on its rising edge.
- `i_reset`, in, 1: reset, synchronous, active-high.
- `i_start`, in, 1: begin a new load; sampled in IDLE, DONE and ERROR.
- `i_byte_valid`, in, 1: `i_byte` is valid.
- `i_byte`, in, 8: source character (ASCII).
- `i_byte_last`, in, 1: qualifies the current byte as the final source byte.
- `o_byte_ready`, out, 1: loader accepts a byte this cycle.
- `o_prgmem_we`, out, 1: program RAM write enable.
- `o_prgmem_addr`, out, PRGMEM_ADDR_WIDTH: write address.
- `o_prgmem_data`, out, INSTR_WIDTH: encoded instruction.
- `o_cpu_hold`, out, 1: high in LOAD and TERM.
- `o_done`, out, 1: load completed successfully.
- `o_error`, out, 2: 00 none, 01 overflow, 10 unbalanced brackets.
- `o_length`, out, PRGMEM_ADDR_WIDTH: number of command words written, excluding the halt word.

## Operation
- Encoding, zero-extended to INSTR_WIDTH:
  - halt = 0000
  - `+` = 0001, `-` = 0010
  - `>` = 0011, `<` = 0100
  - `[` = 0101, `]` = 0110
  - `.` = 0111, `,` = 1000
  - Every other byte is a non-command: accepted and dropped, no write.
- FSM states: IDLE, LOAD, TERM, DONE, ERROR.
- IDLE:
  - `o_byte_ready`=0.
  - `i_start` → LOAD; clears the write pointer, `o_length`, the bracket depth and `o_error`.
- LOAD:
  - `o_byte_ready`=1.
  - On handshake (`valid & ready`) with a command byte: write at pointer, then pointer+1 and `o_length`+1.
  - Pointer limit is 2^W−1, the last slot, reserved for halt. A command arriving at the limit → ERROR with code 01; no write occurs.
  - Handshake with `i_byte_last`=1: the byte is processed normally, then the FSM goes to TERM. Overflow takes priority over TERM.
- TERM:
  - `o_byte_ready`=0.
  - Writes halt at the pointer; pointer and `o_length` are unchanged.
  - Next state: DONE, or ERROR with code 10 if the bracket check fails (see Configuration).
- DONE / ERROR:
  - `o_byte_ready`=0; status is held.
  - `i_start` → LOAD with a full clear.
- `i_start` is ignored in LOAD and TERM.
- Reset from any state:
  - → IDLE.
  - All outputs 0, including `o_prgmem_we`, `o_cpu_hold`, `o_done`, `o_error`, `o_length`.
  - Any partial program in RAM is left as written; the core stays un-held.

## Timing
- Throughput: one byte per cycle in LOAD; `o_byte_ready` is a registered state decode.
- Write outputs are registered. A handshake at edge N drives `o_prgmem_we`/`addr`/`data` during cycle N+1, and the RAM captures at edge N+1.
- `o_prgmem_we` is high for exactly one cycle per write.
- After the last byte's handshake at edge N:
  - TERM is active during cycle N+1.
  - The halt write is driven during cycle N+2.
  - `o_done` or `o_error` rises at edge N+2.
- `o_cpu_hold` rises the cycle after `i_start` is taken. It falls in the same cycle `o_done`/`o_error` rises, after the halt write has been committed.
- Start-to-first-ready latency: 1 cycle.

## Configuration
- `BH_LOADER_BRACKET_CHECK_EN` defined:
  - A depth counter of PRGMEM_ADDR_WIDTH bits: `[` increments it, `]` decrements it.
  - A `]` at depth 0 → immediate ERROR with code 10; no write occurs.
  - In TERM, nonzero depth → ERROR with code 10, after the halt word has been written.
- Not defined:
  - No counter.
  - Brackets are written unchecked.
  - Error code 10 never occurs.

## Test plan
- Reset, then `i_start`, then stream "+[->+<]" with last on `]`:
  - Writes 1,5,2,3,1,4,6 at addresses 0–6, then halt 0 at address 7.
  - `o_length`=7, `o_done`=1, `o_error`=00.
- Stream "a+ b\n." with last on `.`:
  - Only addresses 0 (=1) and 1 (=7) are written, then halt at 2.
  - `o_length`=2; exactly 3 write pulses.
- With PRGMEM_ADDR_WIDTH=2, stream "+++++":
  - Writes at addresses 0–2.
  - The fourth `+` → `o_error`=01, no write at address 3, `o_cpu_hold` falls.
- With the macro defined:
  - "+]" → error 10 after one write.
  - "[[]" with last → halt written at 3, then error 10.
  - With the macro undefined, both streams finish with `o_done`=1.
- Assert `i_reset` mid-load after 3 bytes: the next cycle all outputs are 0 and the state is IDLE. A following `i_start` plus a stream reloads from address 0.
- Toggle `i_byte_valid` randomly during a load: writes occur only on handshake cycles, in order. `i_start` pulses during LOAD have no effect.
